// File: rtl/burst_copy_wf.sv
// rtl/burst_copy_wf.sv - burst memory-to-memory copy engine (read master + FIFO + write master)
//
// Purpose: copies ctrl_length words from ctrl_srcaddress to ctrl_dstaddress as a sequence of
// Avalon-MM bursts of at most BURST_COUNT beats, buffering read data in an internal FIFO.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   ctrl_start/srcaddress/dstaddress/length   copy request (start sampled only in IDLE)
//   ctrl_busy, ctrl_done    status: busy during the copy, one-cycle done pulse
//   rd_*                    burst read master (address/read/burstcount out, waitrequest/readdatavalid/readdata in)
//   wr_*                    burst write master (address/write/writedata/burstcount/byteenable out, waitrequest in)
//   ctrl_checksum           (only with COPY_CHECKSUM_EN) sum mod 2^DATA_WIDTH of all accepted write beats
//
// Optional feature macro: COPY_CHECKSUM_EN
module burst_copy_wf #(
    parameter int ADDRESS_WIDTH          = 32,
    parameter int DATA_WIDTH             = 32,
    parameter int BYTE_ENABLE_WIDTH      = 4,
    parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
    parameter int LENGTH_WIDTH           = 16,
    parameter int BURST_COUNT            = 8,
    parameter int BURST_WIDTH            = 4,
    parameter int FIFO_DEPTH             = 32,
    parameter int FIFO_DEPTH_LOG2        = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_srcaddress,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_dstaddress,
    input  logic [LENGTH_WIDTH-1:0]      ctrl_length,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic [ADDRESS_WIDTH-1:0]     rd_address,
    output logic                         rd_read,
    output logic [BURST_WIDTH-1:0]       rd_burstcount,
    input  logic                         rd_waitrequest,
    input  logic                         rd_readdatavalid,
    input  logic [DATA_WIDTH-1:0]        rd_readdata,
    output logic [ADDRESS_WIDTH-1:0]     wr_address,
    output logic                         wr_write,
    output logic [DATA_WIDTH-1:0]        wr_writedata,
    output logic [BURST_WIDTH-1:0]       wr_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] wr_byteenable,
    input  logic                         wr_waitrequest
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]        ctrl_checksum
`endif
);

    // Counts of words held or in flight can reach FIFO_DEPTH itself, hence one extra bit.
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [LENGTH_WIDTH-1:0]     rd_remaining;
    logic [LENGTH_WIDTH-1:0]     wr_remaining;
    logic [CW-1:0]               rd_pending;
    logic [CW-1:0]               fifo_used;
    logic [FIFO_DEPTH_LOG2-1:0]  fifo_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]  fifo_rd_ptr;
    logic [DATA_WIDTH-1:0]       fifo_mem [FIFO_DEPTH];
    logic [BURST_WIDTH-1:0]      wr_beats_left;

    logic [BURST_WIDTH-1:0]      rd_len;
    logic [BURST_WIDTH-1:0]      wr_len;
    logic [CW-1:0]               fifo_space;
    logic                        rd_accept;
    logic                        wr_accept;
    logic                        push;
    logic                        rd_can_issue;
    logic                        wr_can_start;

    always_comb begin
        rd_len = (rd_remaining >= LENGTH_WIDTH'(BURST_COUNT)) ? BURST_WIDTH'(BURST_COUNT)
                                                             : rd_remaining[BURST_WIDTH-1:0];
        wr_len = (wr_remaining >= LENGTH_WIDTH'(BURST_COUNT)) ? BURST_WIDTH'(BURST_COUNT)
                                                             : wr_remaining[BURST_WIDTH-1:0];
        // Beats only count while a read is outstanding, so stragglers from a copy
        // aborted by reset never land in the FIFO.
        push       = rd_readdatavalid && (rd_pending != '0);
        rd_accept  = rd_read && !rd_waitrequest;
        wr_accept  = wr_write && !wr_waitrequest;
        // Reserving space for every outstanding beat keeps the FIFO from overflowing.
        fifo_space = CW'(FIFO_DEPTH) - fifo_used - rd_pending;
        rd_can_issue = (state == RUN) && !rd_read && (rd_remaining != '0)
                       && (fifo_space >= CW'(rd_len));
        // A whole burst must already be buffered so the write burst never bubbles.
        wr_can_start = (state == RUN) && !wr_write && (wr_remaining != '0)
                       && (fifo_used >= CW'(wr_len));
    end

    assign wr_writedata  = wr_write ? fifo_mem[fifo_rd_ptr] : '0;
    assign wr_byteenable = '1;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= rd_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ctrl_busy     <= 1'b0;
            ctrl_done     <= 1'b0;
            rd_address    <= '0;
            rd_read       <= 1'b0;
            rd_burstcount <= '0;
            wr_address    <= '0;
            wr_write      <= 1'b0;
            wr_burstcount <= '0;
            wr_beats_left <= '0;
            rd_remaining  <= '0;
            wr_remaining  <= '0;
            rd_pending    <= '0;
            fifo_used     <= '0;
            fifo_wr_ptr   <= '0;
            fifo_rd_ptr   <= '0;
`ifdef COPY_CHECKSUM_EN
            ctrl_checksum <= '0;
`endif
        end else begin
            ctrl_done <= 1'b0;

            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (wr_accept) begin
                fifo_rd_ptr <= fifo_rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            fifo_used  <= fifo_used + CW'(push) - CW'(wr_accept);
            rd_pending <= rd_pending + (rd_accept ? CW'(rd_burstcount) : CW'(0)) - CW'(push);

            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        rd_address   <= ctrl_srcaddress & ADDR_MASK;
                        wr_address   <= ctrl_dstaddress & ADDR_MASK;
                        rd_remaining <= ctrl_length;
                        wr_remaining <= ctrl_length;
                        ctrl_busy    <= 1'b1;
`ifdef COPY_CHECKSUM_EN
                        ctrl_checksum <= '0;
`endif
                        state        <= (ctrl_length == '0) ? DONE : RUN;
                    end
                end

                RUN: begin
                    if (rd_accept) begin
                        rd_read      <= 1'b0;
                        rd_address   <= rd_address
                                        + (ADDRESS_WIDTH'(rd_burstcount) << BYTE_ENABLE_WIDTH_LOG2);
                        rd_remaining <= rd_remaining - LENGTH_WIDTH'(rd_burstcount);
                    end else if (rd_can_issue) begin
                        rd_read       <= 1'b1;
                        rd_burstcount <= rd_len;
                    end

                    if (wr_accept) begin
`ifdef COPY_CHECKSUM_EN
                        ctrl_checksum <= ctrl_checksum + wr_writedata;
`endif
                        wr_beats_left <= wr_beats_left - BURST_WIDTH'(1);
                        if (wr_beats_left == BURST_WIDTH'(1)) begin
                            wr_write     <= 1'b0;
                            wr_address   <= wr_address
                                            + (ADDRESS_WIDTH'(wr_burstcount) << BYTE_ENABLE_WIDTH_LOG2);
                            wr_remaining <= wr_remaining - LENGTH_WIDTH'(wr_burstcount);
                        end
                    end else if (wr_can_start) begin
                        wr_write      <= 1'b1;
                        wr_burstcount <= wr_len;
                        wr_beats_left <= wr_len;
                    end

                    if ((wr_remaining == '0) && !wr_write) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    ctrl_busy <= 1'b0;
                    ctrl_done <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_copy_wf.sv
// tb/tb_burst_copy_wf.sv - randomized self-checking bench for burst_copy_wf
module tb_burst_copy_wf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ctrl_start;
    logic [31:0] ctrl_srcaddress;
    logic [31:0] ctrl_dstaddress;
    logic [15:0] ctrl_length;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic [31:0] rd_address;
    logic        rd_read;
    logic [3:0]  rd_burstcount;
    logic        rd_waitrequest;
    logic        rd_readdatavalid;
    logic [31:0] rd_readdata;
    logic [31:0] wr_address;
    logic        wr_write;
    logic [31:0] wr_writedata;
    logic [3:0]  wr_burstcount;
    logic [3:0]  wr_byteenable;
    logic        wr_waitrequest;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] ctrl_checksum;
`endif

    always #5 clk = ~clk;

    burst_copy_wf dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ctrl_start       (ctrl_start),
        .ctrl_srcaddress  (ctrl_srcaddress),
        .ctrl_dstaddress  (ctrl_dstaddress),
        .ctrl_length      (ctrl_length),
        .ctrl_busy        (ctrl_busy),
        .ctrl_done        (ctrl_done),
        .rd_address       (rd_address),
        .rd_read          (rd_read),
        .rd_burstcount    (rd_burstcount),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdatavalid (rd_readdatavalid),
        .rd_readdata      (rd_readdata),
        .wr_address       (wr_address),
        .wr_write         (wr_write),
        .wr_writedata     (wr_writedata),
        .wr_burstcount    (wr_burstcount),
        .wr_byteenable    (wr_byteenable),
        .wr_waitrequest   (wr_waitrequest)
`ifdef COPY_CHECKSUM_EN
        ,
        .ctrl_checksum    (ctrl_checksum)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state: source memory is "base + word index", the copy is a list of words.
    logic [31:0] src_al;
    logic [31:0] dst_al;
    logic [31:0] base;
    logic [31:0] rdq [$];
    int          rd_issued;
    int          wr_done;
    int          occ;
    int          max_occ;
    logic [31:0] sum;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return base + ((a - src_al) >> 2);
    endfunction

    function automatic int min8(input int r);
        return (r < 8) ? r : 8;
    endfunction

    task automatic do_abort();
        int dones;
        check("abort_mid_burst", wr_write, 1);
        reset_n = 1'b0;
        #1;
        check("abort_ctl", {rd_read, wr_write, ctrl_busy, ctrl_done, rd_burstcount, wr_burstcount}, 0);
        check("abort_addr", {rd_address, wr_address}, 0);
        check("abort_wdata", wr_writedata, 0);
        check("abort_be", wr_byteenable, 4'hF);
        rd_readdatavalid = 1'b0;
        rd_waitrequest   = 1'b0;
        wr_waitrequest   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // Late beats of the aborted reads must be dropped.
        rd_readdatavalid = 1'b1;
        rd_readdata      = 32'hDEAD_BEEF;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ctrl_done || ctrl_busy) dones++;
        end
        rd_readdatavalid = 1'b0;
        check("abort_no_done", dones, 0);
    endtask

    task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int mode, input bit mid_start, input int abort_word,
                           input logic [31:0] b);
        int          cyc, rcnt, wleft, extra, done_cyc, exp_l;
        bit          done_seen, busy_gap, prev_rstall, wtog, saw_rd, saw_wr;
        logic [31:0] p_raddr, waddr_b;
        logic [3:0]  p_rbc, wbc_b;
        src_al = src & 32'hFFFF_FFFC;
        dst_al = dst & 32'hFFFF_FFFC;
        base   = b;
        rdq.delete();
        rd_issued = 0; wr_done = 0; occ = 0; max_occ = 0; sum = '0;
        rcnt = 0; wleft = 0; done_cyc = -1; done_seen = 0; busy_gap = 0;
        prev_rstall = 0; wtog = 0; saw_rd = 0; saw_wr = 0;
        p_raddr = '0; waddr_b = '0; p_rbc = '0; wbc_b = '0;
        @(negedge clk);
        ctrl_start      = 1'b1;
        ctrl_srcaddress = src;
        ctrl_dstaddress = dst;
        ctrl_length     = 16'(len);
        @(negedge clk);
        ctrl_start = 1'b0;
        cyc = 1;
        while (cyc < 4000) begin
            if (abort_word >= 0 && wr_done >= abort_word) begin
                do_abort();
                return;
            end
            if (ctrl_done) begin
                done_seen = 1;
                done_cyc  = cyc;
                break;
            end
            if (!ctrl_busy) busy_gap = 1;
            if (mid_start) begin
                ctrl_start = (cyc == 5);
                if (cyc == 5) begin
                    ctrl_srcaddress = 32'h1234_5670;
                    ctrl_length     = 16'd3;
                end
            end
            // read data return
            if (rdq.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                rd_readdatavalid = 1'b1;
                rd_readdata      = data_of(rdq.pop_front());
                occ++;
            end else begin
                rd_readdatavalid = 1'b0;
                rd_readdata      = $urandom;
            end
            // read requests
            if (rd_read) begin
                saw_rd = 1;
                if (prev_rstall) begin
                    check("rd_addr_hold", rd_address, p_raddr);
                    check("rd_bc_hold", rd_burstcount, p_rbc);
                end
                case (mode)
                    0: rd_waitrequest = 1'b0;
                    1: begin
                        rd_waitrequest = (rcnt < 3);
                        rcnt = (rcnt < 3) ? rcnt + 1 : 0;
                    end
                    default: rd_waitrequest = ($urandom_range(0, 2) == 0);
                endcase
                if (!rd_waitrequest) begin
                    exp_l = min8(len - rd_issued);
                    check("rd_addr", rd_address, src_al + 4 * rd_issued);
                    check("rd_bc", rd_burstcount, exp_l);
                    for (int i = 0; i < exp_l; i++) rdq.push_back(src_al + 4 * (rd_issued + i));
                    rd_issued += exp_l;
                end
                prev_rstall = rd_waitrequest;
                p_raddr = rd_address;
                p_rbc   = rd_burstcount;
            end else begin
                if (prev_rstall) check("rd_read_hold", rd_read, 1);
                prev_rstall = 0;
                rcnt = 0;
                rd_waitrequest = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            // write requests
            if (wr_write) begin
                saw_wr = 1;
                if (wleft <= 0) begin
                    exp_l = min8(len - wr_done);
                    check("wr_addr", wr_address, dst_al + 4 * wr_done);
                    check("wr_bc", wr_burstcount, exp_l);
                    wleft   = exp_l;
                    waddr_b = wr_address;
                    wbc_b   = wr_burstcount;
                end else begin
                    check("wr_addr_hold", wr_address, waddr_b);
                    check("wr_bc_hold", wr_burstcount, wbc_b);
                end
                case (mode)
                    0: wr_waitrequest = 1'b0;
                    1: begin
                        wtog = !wtog;
                        wr_waitrequest = wtog;
                    end
                    default: wr_waitrequest = ($urandom_range(0, 2) == 0);
                endcase
                if (!wr_waitrequest) begin
                    check("wr_data", wr_writedata, data_of(src_al + 4 * wr_done));
                    sum += wr_writedata;
                    wr_done++;
                    wleft--;
                    occ--;
                end
            end else begin
                if (wleft > 0) check("wr_burst_gap", wr_write, 1);
                wr_waitrequest = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (occ > max_occ) max_occ = occ;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done_seen, 1);
        rd_readdatavalid = 1'b0;
        rd_waitrequest   = 1'b0;
        wr_waitrequest   = 1'b0;
        if (done_seen) begin
            check("busy_at_done", ctrl_busy, 0);
            check("busy_gap", busy_gap, 0);
            check("words_written", wr_done, len);
            check("words_read", rd_issued, len);
            check("rdq_empty", rdq.size(), 0);
            check("fifo_bound", max_occ <= 32, 1);
`ifdef COPY_CHECKSUM_EN
            check("checksum", ctrl_checksum, sum);
`endif
            if (len == 0) begin
                check("len0_done_cycle", done_cyc, 2);
                check("len0_no_bus", {saw_rd, saw_wr}, 0);
            end
            extra = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (ctrl_done) extra++;
            end
            check("single_done", extra, 0);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        ctrl_start       = 1'b0;
        ctrl_srcaddress  = '0;
        ctrl_dstaddress  = '0;
        ctrl_length      = '0;
        rd_waitrequest   = 1'b0;
        rd_readdatavalid = 1'b0;
        rd_readdata      = '0;
        wr_waitrequest   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {rd_read, wr_write, ctrl_busy, ctrl_done, rd_burstcount, wr_burstcount}, 0);
        check("reset_addr", {rd_address, wr_address}, 0);
        check("reset_wdata", wr_writedata, 0);
        check("reset_be", wr_byteenable, 4'hF);
        reset_n = 1'b1;
        @(negedge clk);

        do_copy(32'h3800_0000, 32'h3900_0000, 16, 0, 0, -1, 32'd0);
        do_copy(32'h3800_0000, 32'h3900_0000, 13, 0, 0, -1, 32'd100);
        do_copy(32'h3800_0000, 32'h3900_0000, 20, 1, 0, -1, 32'h5000);
        do_copy(32'h3800_0000, 32'h3900_0000, 0, 0, 0, -1, 32'd0);
        do_copy(32'h3800_0000, 32'h3900_0000, 24, 0, 1, 10, 32'h7700);
        do_copy(32'h3A00_0000, 32'h3B00_0000, 8, 0, 0, -1, $urandom);
`ifdef COPY_CHECKSUM_EN
        do_copy(32'h0000_0100, 32'h0000_0200, 4, 0, 0, -1, 32'd1);
        check("checksum_1234", ctrl_checksum, 10);
`endif
        for (int t = 0; t < 8; t++) begin
            do_copy($urandom & 32'h0FFF_FFFF, $urandom & 32'h0FFF_FFFF,
                    $urandom_range(1, 45), 2, 0, -1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
